// File: rtl/ptp_tx_gen.sv
// ptp_tx_gen: builds Ethernet/IPv4/UDP/PTPv2 event frames and streams them as 32-bit words
//   clk, rst          : clock, synchronous active-high reset
//   tx_req_i          : start-frame request, taken only while tx_busy_o=0
//   tx_msgid_i        : PTP messageType captured with the request
//   ptp_time_i        : {seconds[47:0], ns[31:0]}, latched at request
//   ptp_ready_i       : downstream accept
//   ptp_data_o/valid_o/sop_o/eop_o/mod_o : 23-word frame stream, byte 0 in [31:24]
//   tx_busy_o         : frame in progress
//   tx_done_o         : one-cycle pulse after the eop word transfers
//   tx_infor_o        : {msgid, seqid, time} valid with tx_done_o, else 0
module ptp_tx_gen #(
    parameter logic [31:0] PREFIX  = 32'h00000000,
    parameter logic [47:0] DST_MAC = 48'h011B19000000,
    parameter logic [47:0] SRC_MAC = 48'h000A35000001,
    parameter logic [31:0] SRC_IP  = 32'hC0A80001,
    parameter logic [31:0] DST_IP  = 32'hE0000181,
    parameter logic [7:0]  DOMAIN  = 8'h00,
    parameter logic [79:0] PORT_ID = 80'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_req_i,
    input  logic [3:0]   tx_msgid_i,
    input  logic [79:0]  ptp_time_i,
    input  logic         ptp_ready_i,
    output logic [31:0]  ptp_data_o,
    output logic         ptp_valid_o,
    output logic         ptp_sop_o,
    output logic         ptp_eop_o,
    output logic [1:0]   ptp_mod_o,
    output logic         tx_busy_o,
    output logic         tx_done_o,
    output logic [99:0]  tx_infor_o
);
    // The IPv4 header is fixed apart from the addresses, so its checksum is a constant.
    function automatic logic [15:0] ip_csum(input logic [31:0] sip, input logic [31:0] dip);
        logic [19:0] s;
        s = 20'h4500 + 20'h0048 + 20'h4000 + 20'h0111
          + 20'(sip[31:16]) + 20'(sip[15:0]) + 20'(dip[31:16]) + 20'(dip[15:0]);
        s = 20'(s[15:0]) + 20'(s[19:16]);
        s = 20'(s[15:0]) + 20'(s[19:16]);
        return ~s[15:0];
    endfunction
    localparam logic [15:0] IP_CSUM = ip_csum(SRC_IP, DST_IP);
    localparam logic [4:0]  LAST    = 5'd22;
    typedef enum logic {IDLE, SEND} state_e;
    state_e        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [3:0]    msgid_q, msgid_d;
    logic [79:0]   time_q, time_d;
    logic [15:0]   seq_q, seq_d;
    logic          done_q, done_d;
    logic [99:0]   infor_q, infor_d;
    logic [31:0]   word;
    logic          send, xfer;
    assign send = state_q == SEND;
    assign xfer = send && ptp_ready_i;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        msgid_d = msgid_q;
        time_d  = time_q;
        seq_d   = seq_q;
        done_d  = 1'b0;
        infor_d = 100'h0;
        if (!send && tx_req_i) begin
            state_d = SEND;
            idx_d   = 5'd0;
            msgid_d = tx_msgid_i;
            time_d  = ptp_time_i;
        end
        if (xfer) begin
            idx_d = idx_q + 5'd1;
            if (idx_q == LAST) begin
                state_d = IDLE;
                idx_d   = 5'd0;
                done_d  = 1'b1;
                infor_d = {msgid_q, seq_q, time_q};
                seq_d   = seq_q + 16'd1;
            end
        end
    end
    always_comb begin
        word = 32'h0;
        case (idx_q)
            5'd0:    word = PREFIX;
            5'd1:    word = DST_MAC[47:16];
            5'd2:    word = {DST_MAC[15:0], SRC_MAC[47:32]};
            5'd3:    word = SRC_MAC[31:0];
            5'd4:    word = 32'h08004500;
            5'd5:    word = 32'h00480000;
            5'd6:    word = 32'h40000111;
            5'd7:    word = {IP_CSUM, SRC_IP[31:16]};
            5'd8:    word = {SRC_IP[15:0], DST_IP[31:16]};
            5'd9:    word = {DST_IP[15:0], 16'h013F};
            5'd10:   word = 32'h013F0034;
            5'd11:   word = {20'h0, msgid_q, 8'h02};
            5'd12:   word = {16'h002C, DOMAIN, 8'h00};
            5'd16:   word = {16'h0000, PORT_ID[79:64]};
            5'd17:   word = PORT_ID[63:32];
            5'd18:   word = PORT_ID[31:0];
            5'd19:   word = {seq_q, 7'h0, msgid_q != 4'h0, 8'h7F};
            5'd20:   word = time_q[79:48];
            5'd21:   word = {time_q[47:32], time_q[31:16]};
            5'd22:   word = {time_q[15:0], 16'h0000};
            default: word = 32'h0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            msgid_q <= 4'h0;
            time_q  <= 80'h0;
            seq_q   <= 16'h0;
            done_q  <= 1'b0;
            infor_q <= 100'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            msgid_q <= msgid_d;
            time_q  <= time_d;
            seq_q   <= seq_d;
            done_q  <= done_d;
            infor_q <= infor_d;
        end
    end
    assign ptp_valid_o = send;
    assign tx_busy_o   = send;
    assign ptp_data_o  = send ? word : 32'h0;
    assign ptp_sop_o   = send && idx_q == 5'd0;
    assign ptp_eop_o   = send && idx_q == LAST;
    assign ptp_mod_o   = ptp_eop_o ? 2'd2 : 2'd0;
    assign tx_done_o   = done_q;
    assign tx_infor_o  = infor_q;
endmodule

// File: tb/tb_ptp_tx_gen.sv
// tb_ptp_tx_gen: scoreboard bench for ptp_tx_gen with a byte-level frame model
module tb_ptp_tx_gen;
    localparam logic [31:0] PREFIX  = 32'h00000000;
    localparam logic [47:0] DST_MAC = 48'h011B19000000;
    localparam logic [47:0] SRC_MAC = 48'h000A35000001;
    localparam logic [31:0] SRC_IP  = 32'hC0A80001;
    localparam logic [31:0] DST_IP  = 32'hE0000181;
    localparam logic [7:0]  DOMAIN  = 8'h00;
    localparam logic [79:0] PORT_ID = 80'h0;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
    } wrd_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_req = 1'b0;
    logic [3:0]   tx_msgid = 4'h0;
    logic [79:0]  ptp_time = 80'h0;
    logic         ptp_ready = 1'b1;
    logic [31:0]  ptp_data;
    logic         ptp_valid, ptp_sop, ptp_eop;
    logic [1:0]   ptp_mod;
    logic         tx_busy, tx_done;
    logic [99:0]  tx_infor;

    int           total = 0;
    int           bad = 0;
    wrd_t         wq[$];
    logic [99:0]  iq[$];
    logic [7:0]   fb [0:91];
    logic [15:0]  model_seq = 16'h0;
    logic         ready_rand = 1'b0;
    int           widx = 0;
    logic         exp_done = 1'b0;
    logic         stall = 1'b0;
    wrd_t         held;

    ptp_tx_gen dut (
        .clk(clk), .rst(rst),
        .tx_req_i(tx_req), .tx_msgid_i(tx_msgid), .ptp_time_i(ptp_time),
        .ptp_ready_i(ptp_ready),
        .ptp_data_o(ptp_data), .ptp_valid_o(ptp_valid), .ptp_sop_o(ptp_sop),
        .ptp_eop_o(ptp_eop), .ptp_mod_o(ptp_mod), .tx_busy_o(tx_busy),
        .tx_done_o(tx_done), .tx_infor_o(tx_infor)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always begin
        @(posedge clk);
        #1 ptp_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    function automatic void put(input int pos, input logic [79:0] v, input int n);
        for (int k = 0; k < n; k++) fb[pos + k] = 8'(v >> (8 * (n - 1 - k)));
    endfunction

    // Lays the frame out byte by byte as it appears on the wire, then cuts it into words.
    task automatic push_frame(input logic [3:0] m, input logic [15:0] s, input logic [79:0] t);
        int sum;
        wrd_t w;
        for (int k = 0; k < 92; k++) fb[k] = 8'h0;
        put(0, 80'(PREFIX), 4);
        put(4, 80'(DST_MAC), 6);
        put(10, 80'(SRC_MAC), 6);
        put(16, 80'h0800, 2);
        put(18, 80'h4500, 2);
        put(20, 80'd72, 2);
        put(24, 80'h4000, 2);
        fb[26] = 8'd1;
        fb[27] = 8'd17;
        put(30, 80'(SRC_IP), 4);
        put(34, 80'(DST_IP), 4);
        sum = 0;
        for (int h = 0; h < 10; h++) sum += int'({fb[18 + 2 * h], fb[19 + 2 * h]});
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        put(28, 80'(16'(~sum)), 2);
        put(38, 80'd319, 2);
        put(40, 80'd319, 2);
        put(42, 80'd52, 2);
        fb[46] = {4'h0, m};
        fb[47] = 8'h02;
        put(48, 80'd44, 2);
        fb[50] = DOMAIN;
        put(66, PORT_ID, 10);
        put(76, 80'(s), 2);
        fb[78] = (m == 4'h0) ? 8'h00 : 8'h01;
        fb[79] = 8'h7F;
        put(80, 80'(t[79:32]), 6);
        put(86, 80'(t[31:0]), 4);
        for (int i = 0; i < 23; i++) begin
            w.d   = {fb[4 * i], fb[4 * i + 1], fb[4 * i + 2], fb[4 * i + 3]};
            w.sop = i == 0;
            w.eop = i == 22;
            w.mod = (i == 22) ? 2'd2 : 2'd0;
            wq.push_back(w);
        end
        iq.push_back({m, s, t});
    endtask

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
            widx = 0;
            exp_done = 1'b0;
        end else begin
            if (exp_done || tx_done) begin
                chk("tx_done_pulse", 100'(tx_done), 100'(exp_done));
                if (tx_done) begin
                    if (iq.size() == 0) chk("tx_infor_unexpected", tx_infor, 100'h0);
                    else chk("tx_infor", tx_infor, iq.pop_front());
                end
            end else if (tx_infor !== 100'h0) begin
                chk("tx_infor_idle", tx_infor, 100'h0);
            end
            exp_done = 1'b0;
            chk("busy_eq_valid", 100'(tx_busy), 100'(ptp_valid));
            if (ptp_valid && stall)
                chk("hold_under_backpressure", 100'({ptp_data, ptp_sop, ptp_eop, ptp_mod}), 100'(held));
            if (ptp_valid && ptp_ready) begin
                if (wq.size() == 0) begin
                    chk("word_unexpected", 100'(ptp_data), 100'h0);
                    bad += (ptp_data == 32'h0) ? 1 : 0;
                end else begin
                    automatic wrd_t e = wq.pop_front();
                    total++;
                    if ({ptp_data, ptp_sop, ptp_eop, ptp_mod} !== e) begin
                        bad++;
                        $display("FAIL word%0d: got d=%h sop=%b eop=%b mod=%0d expected d=%h sop=%b eop=%b mod=%0d",
                                 widx, ptp_data, ptp_sop, ptp_eop, ptp_mod, e.d, e.sop, e.eop, e.mod);
                    end
                end
                widx++;
                if (ptp_eop) begin
                    exp_done = 1'b1;
                    widx = 0;
                end
                stall = 1'b0;
            end else if (ptp_valid) begin
                stall = 1'b1;
                held = {ptp_data, ptp_sop, ptp_eop, ptp_mod};
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic send(input logic [3:0] m, input logic [79:0] t);
        int n = 0;
        while (tx_busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_wait_idle", 100'(tx_busy), 100'h0);
        tx_req = 1'b1;
        tx_msgid = m;
        ptp_time = t;
        push_frame(m, model_seq, t);
        model_seq++;
        @(posedge clk);
        #1;
        tx_req = 1'b0;
        tx_msgid = 4'($urandom);
        ptp_time = {16'($urandom), $urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || iq.size() != 0 || tx_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_words_left", 100'(wq.size()), 100'h0);
        chk("drain_reports_left", 100'(iq.size()), 100'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_widx(input int target);
        int n = 0;
        while (widx != target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_word_index", 100'(widx), 100'(target));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 100'(ptp_valid), 100'h0);
        chk("rst_busy", 100'(tx_busy), 100'h0);
        chk("rst_done", 100'(tx_done), 100'h0);
        chk("rst_infor", tx_infor, 100'h0);
        chk("rst_data", 100'({ptp_data, ptp_sop, ptp_eop, ptp_mod}), 100'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(4'h0, {48'h1, 32'h10});
        drain();

        send(4'h1, {48'h0000_1234_5678, 32'h3B9A_C9FF});
        send(4'h0, {48'hFFFF_FFFF_FFFF, 32'h0000_0001});
        drain();

        ready_rand = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), {16'($urandom), $urandom, $urandom});
            if (($urandom & 1) != 0) drain();
        end
        drain();
        ready_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        model_seq = 16'hFFFF;
        send(4'h1, {48'hABCD, 32'h55});
        send(4'h0, {48'hABCE, 32'h66});
        drain();

        send(4'h1, {48'h77, 32'h88});
        wait_widx(10);
        tx_req = 1'b1;
        tx_msgid = 4'h3;
        @(posedge clk);
        #1 tx_req = 1'b0;
        drain();

        send(4'h0, {48'h99, 32'hAA});
        wait_widx(12);
        rst = 1'b1;
        wq.delete();
        iq.delete();
        model_seq = 16'h0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 100'(ptp_valid), 100'h0);
        chk("midrst_busy", 100'(tx_busy), 100'h0);
        chk("midrst_done", 100'(tx_done), 100'h0);
        chk("midrst_infor", tx_infor, 100'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(4'h1, {48'hBB, 32'hCC});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
